wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file of the 32-bit MIPS pipeline, the consumer of the MEM/WB pipeline register outputs. It selects the write-back value (memory data or ALU result) and commits it to a 32-entry register file on the rising clock edge. It also provides two combinational read ports to the ID stage. Register `$zero` is hard-wired to 0.

## Interface
Parameters:
- `n`, 32, data width in bits.
- `ADDR_W`, 5, register address width; depth is `2**ADDR_W`.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `Reg_Write_in`  input  1  write enable, from MEM/WB register.
- `MemtoReg_in`  input  1  1 = write memory data, 0 = write ALU result.
- `data_memory_output_in`  input  n  load data from MEM/WB.
- `ALU_Output_in`  input  n  ALU result from MEM/WB.
- `MEM_WB_Rd_in`  input  ADDR_W  destination register.
- `Read_Reg1_in`  input  ADDR_W  ID-stage source address rs.
- `Read_Reg2_in`  input  ADDR_W  ID-stage source address rt.
- `Read_Data1_out`  output  n  contents of rs.
- `Read_Data2_out`  output  n  contents of rt.
- `WB_Data_out`  output  n  selected write-back value, driven to EX forwarding muxes.
- `WB_Valid_out`  output  1  high when a commit to a nonzero register happens this cycle.

## Operation
- WB_Data_out = MemtoReg_in ? data_memory_output_in : ALU_Output_in. This path is always combinational and is not gated by Reg_Write_in.
- Commit condition: Reg_Write_in && MEM_WB_Rd_in != 0 && !rst. WB_Valid_out equals this condition combinationally.
- On a rising edge with the commit condition true: `regs[MEM_WB_Rd_in] <= WB_Data_out`. Otherwise the file is unchanged.
- Writes to register 0 are silently discarded. Reads of register 0 always return 0.
- Read ports are asynchronous. Read_DataX_out = regs[Read_RegX_in], subject to the bypass described under Configuration.
- Both read ports may address the same register, and may address the write target. Each port resolves independently.

## Timing
- Reset: on a rising edge with rst=1, all entries become 0. rst overrides any write in the same cycle.
- While rst=1: Read_Data1_out, Read_Data2_out and WB_Valid_out are forced to 0. WB_Data_out is not affected.
- Write latency: the value is stored at edge k. Without bypass it is visible on the read ports after edge k.
- Read latency: 0 cycles (combinational from address).
- Reset mid-stream: a pending write presented in the rst cycle is lost. Normal writes resume on the first edge with rst=0.
- No handshake; the pipeline never stalls this block.

## Configuration
- `WB_REGFILE_BYPASS_EN` defined:
  - Internal write-first forwarding is enabled.
  - If the commit condition is true and Read_RegX_in == MEM_WB_Rd_in, Read_DataX_out = WB_Data_out in the same cycle.
  - This removes the WB→ID hazard.
- Undefined:
  - Reads return the stored value only.
  - The hazard unit must stall one cycle for this case.

## Structure
- Shared package `mips_pkg`:
  - `REG_ZERO` constant (5'd0).
  - Default data width constant and register-address typedef.
  - Shared with ID/EX/MEM stages.
- One sub-module, `wb_mux`: the 2:1 MemtoReg select producing WB_Data_out.
- Storage is a flat register array inside `wb_regfile`.

## Test plan
- Reset and zero register:
  - Assert rst for 1 cycle, then release.
  - Read registers 0..31 → all 0x00000000.
  - Write 0xDEADBEEF to r0 → r0 still reads 0 and WB_Valid_out=0.
- MemtoReg select, MemtoReg_in=1:
  - Set data_memory_output_in=0x00000007, ALU_Output_in=0x12345678, Rd=5, Reg_Write_in=1.
  - Next cycle, Read_Reg1_in=5 → 0x00000007.
- MemtoReg select, MemtoReg_in=0:
  - Same inputs as above → r5 reads 0x12345678.
- Write-disabled:
  - Reg_Write_in=0, Rd=9, ALU_Output_in=0xFFFFFFFF → r9 stays at its previous value and WB_Valid_out=0.
- Same-cycle read of the write target:
  - Write 0xA5A5A5A5 to r3 while Read_Reg1_in=Read_Reg2_in=3.
  - With `WB_REGFILE_BYPASS_EN`: both ports read 0xA5A5A5A5 in that cycle.
  - Without it: both ports read the old value, then 0xA5A5A5A5 after the edge.
- Reset collision:
  - Preload r7=0x11111111.
  - Assert rst in the same cycle as a write of 0x22222222 to r7.
  - After release, r7 reads 0x00000000.
  - During rst, both read ports read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Definitions shared by the ID/EX/MEM/WB stages of the 32-bit MIPS pipeline:
//   DATA_W      default datapath width
//   REG_ADDR_W  register address width
//   reg_addr_t  register address type
//   REG_ZERO    address of the hard-wired zero register ($zero)
//   wb_src_e    encoding of the MemtoReg control bit
//   is_reg_zero helper that tests an address against REG_ZERO
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // MemtoReg encoding: 1 selects load data, 0 selects the ALU result.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic is_reg_zero(input reg_addr_t addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_mux.sv
// wb_mux
// Write-back source select. Purely combinational.
// Ports:
//   sel_in       MemtoReg control (1 = memory data, 0 = ALU result)
//   mem_data_in  load data from the MEM/WB register
//   alu_data_in  ALU result from the MEM/WB register
//   wb_data_out  selected write-back value
module wb_mux
  import mips_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic         sel_in,
  input  logic [n-1:0] mem_data_in,
  input  logic [n-1:0] alu_data_in,
  output logic [n-1:0] wb_data_out
);

  wb_src_e src;

  assign src         = wb_src_e'(sel_in);
  assign wb_data_out = (src == WB_SRC_MEM) ? mem_data_in : alu_data_in;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
// Write-back stage and architectural register file of the MIPS pipeline.
// Selects the write-back value, commits it to a 2**ADDR_W entry register file
// on the rising edge of clk and serves two asynchronous read ports to ID.
// Register 0 is hard-wired to zero.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to forward a same-cycle commit
// straight to a read port that addresses the write target (write-first).
//
// Ports:
//   clk                    clock, all state changes on the rising edge
//   rst                    synchronous active-high reset, clears all entries
//   Reg_Write_in           write enable from MEM/WB
//   MemtoReg_in            1 = write memory data, 0 = write ALU result
//   data_memory_output_in  load data from MEM/WB
//   ALU_Output_in          ALU result from MEM/WB
//   MEM_WB_Rd_in           destination register
//   Read_Reg1_in/2_in      ID-stage source addresses (rs, rt)
//   Read_Data1_out/2_out   contents of rs / rt (0 while rst is high)
//   WB_Data_out            selected write-back value (never gated)
//   WB_Valid_out           high when a commit to a nonzero register happens
module wb_regfile
  import mips_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Reg_Write_in,
  input  logic              MemtoReg_in,
  input  logic [n-1:0]      data_memory_output_in,
  input  logic [n-1:0]      ALU_Output_in,
  input  logic [ADDR_W-1:0] MEM_WB_Rd_in,
  input  logic [ADDR_W-1:0] Read_Reg1_in,
  input  logic [ADDR_W-1:0] Read_Reg2_in,
  output logic [n-1:0]      Read_Data1_out,
  output logic [n-1:0]      Read_Data2_out,
  output logic [n-1:0]      WB_Data_out,
  output logic              WB_Valid_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [n-1:0]      wb_data;
  logic              commit;
  logic [n-1:0]      regs [DEPTH];

  // Both read ports are built from one template, indexed by port number.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [n-1:0]      rd_data [2];

  // --------------------------------------------------------------------
  // Write-back value select
  // --------------------------------------------------------------------
  wb_mux #(
    .n (n)
  ) u_wb_mux (
    .sel_in      (MemtoReg_in),
    .mem_data_in (data_memory_output_in),
    .alu_data_in (ALU_Output_in),
    .wb_data_out (wb_data)
  );

  assign WB_Data_out = wb_data;

  // A write to $zero is not a commit, so it neither updates storage nor
  // raises WB_Valid_out. Reset masks the commit in the same cycle.
  assign commit       = Reg_Write_in && (MEM_WB_Rd_in != ZERO_ADDR) && !rst;
  assign WB_Valid_out = commit;

  // --------------------------------------------------------------------
  // Storage. Entry 0 is cleared by reset and never written afterwards
  // (commit excludes it); the read mux also forces it to zero so the
  // pre-reset contents of entry 0 can never leak out.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[MEM_WB_Rd_in] <= wb_data;
    end
  end

  // --------------------------------------------------------------------
  // Asynchronous read ports
  // --------------------------------------------------------------------
  assign rd_addr[0] = Read_Reg1_in;
  assign rd_addr[1] = Read_Reg2_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = regs[rd_addr[gi]];
`ifdef WB_REGFILE_BYPASS_EN
        // Write-first: the value committing at the coming edge is visible
        // now, closing the WB->ID hazard without a stall.
        if (commit && (rd_addr[gi] == MEM_WB_Rd_in)) begin
          rd_data[gi] = wb_data;
        end
`endif
        if (rd_addr[gi] == ZERO_ADDR) begin
          rd_data[gi] = '0;
        end
        if (rst) begin
          rd_data[gi] = '0;
        end
      end
    end
  endgenerate

  assign Read_Data1_out = rd_data[0];
  assign Read_Data2_out = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
// Directed self-checking bench for wb_regfile. Inputs change 1 time unit
// after a rising edge; outputs are checked 1 time unit after that, well
// before the next rising edge.
module tb_wb_regfile;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          Reg_Write_in;
  logic          MemtoReg_in;
  logic [N-1:0]  data_memory_output_in;
  logic [N-1:0]  ALU_Output_in;
  logic [AW-1:0] MEM_WB_Rd_in;
  logic [AW-1:0] Read_Reg1_in;
  logic [AW-1:0] Read_Reg2_in;
  logic [N-1:0]  Read_Data1_out;
  logic [N-1:0]  Read_Data2_out;
  logic [N-1:0]  WB_Data_out;
  logic          WB_Valid_out;

  int checks = 0;
  int passed = 0;
  logic [N-1:0] exp_same;

  always #5 clk = ~clk;

  wb_regfile #(
    .n      (N),
    .ADDR_W (AW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .Reg_Write_in          (Reg_Write_in),
    .MemtoReg_in           (MemtoReg_in),
    .data_memory_output_in (data_memory_output_in),
    .ALU_Output_in         (ALU_Output_in),
    .MEM_WB_Rd_in          (MEM_WB_Rd_in),
    .Read_Reg1_in          (Read_Reg1_in),
    .Read_Reg2_in          (Read_Reg2_in),
    .Read_Data1_out        (Read_Data1_out),
    .Read_Data2_out        (Read_Data2_out),
    .WB_Data_out           (WB_Data_out),
    .WB_Valid_out          (WB_Valid_out)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  // Advance to just after the next rising edge so new inputs can be applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic we, input logic m2r, input logic [N-1:0] mem,
                          input logic [N-1:0] alu, input logic [AW-1:0] rd);
    Reg_Write_in          = we;
    MemtoReg_in           = m2r;
    data_memory_output_in = mem;
    ALU_Output_in         = alu;
    MEM_WB_Rd_in          = rd;
  endtask

  initial begin
    rst          = 1'b1;
    Read_Reg1_in = '0;
    Read_Reg2_in = '0;
    drive_wr(1'b1, 1'b0, 32'h0000_0000, 32'h5555_AAAA, 5'd3);

    // Reset cycle: write masked, reads forced to 0, WB data still driven.
    #1;
    Read_Reg1_in = 5'd3;
    Read_Reg2_in = 5'd3;
    #1;
    chk("rst_valid", {31'd0, WB_Valid_out}, 32'd0);
    chk("rst_wbdata", WB_Data_out, 32'h5555_AAAA);
    chk("rst_rd1", Read_Data1_out, 32'd0);
    step();

    // Release reset; every register must read zero.
    rst = 1'b0;
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      Read_Reg1_in = AW'(i);
      Read_Reg2_in = AW'(31 - i);
      #1;
      chk($sformatf("zero_rd1_r%0d", i), Read_Data1_out, 32'd0);
      chk($sformatf("zero_rd2_r%0d", 31 - i), Read_Data2_out, 32'd0);
    end

    // Write to r0 is discarded and not flagged.
    drive_wr(1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF, 5'd0);
    Read_Reg1_in = 5'd0;
    #1;
    chk("r0_valid", {31'd0, WB_Valid_out}, 32'd0);
    chk("r0_wbdata", WB_Data_out, 32'hDEAD_BEEF);
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("r0_after", Read_Data1_out, 32'd0);

    // MemtoReg=1 writes memory data to r5.
    drive_wr(1'b1, 1'b1, 32'h0000_0007, 32'h1234_5678, 5'd5);
    #1;
    chk("m2r1_valid", {31'd0, WB_Valid_out}, 32'd1);
    chk("m2r1_wbdata", WB_Data_out, 32'h0000_0007);
    step();
    drive_wr(1'b0, 1'b1, 32'h0000_0007, 32'h1234_5678, 5'd5);
    Read_Reg1_in = 5'd5;
    #1;
    chk("m2r1_r5", Read_Data1_out, 32'h0000_0007);

    // MemtoReg=0 writes the ALU result to r5.
    drive_wr(1'b1, 1'b0, 32'h0000_0007, 32'h1234_5678, 5'd5);
    #1;
    chk("m2r0_wbdata", WB_Data_out, 32'h1234_5678);
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("m2r0_r5", Read_Data1_out, 32'h1234_5678);

    // Preload r9, then a disabled write must leave it alone.
    drive_wr(1'b1, 1'b0, 32'd0, 32'h0000_0099, 5'd9);
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd9);
    Read_Reg2_in = 5'd9;
    #1;
    chk("wdis_valid", {31'd0, WB_Valid_out}, 32'd0);
    chk("wdis_wbdata", WB_Data_out, 32'hFFFF_FFFF);
    step();
    #1;
    chk("wdis_r9", Read_Data2_out, 32'h0000_0099);

    // Same-cycle read of the write target r3 (old value 0).
    drive_wr(1'b1, 1'b0, 32'd0, 32'hA5A5_A5A5, 5'd3);
    Read_Reg1_in = 5'd3;
    Read_Reg2_in = 5'd3;
`ifdef WB_REGFILE_BYPASS_EN
    exp_same = 32'hA5A5_A5A5;
`else
    exp_same = 32'h0000_0000;
`endif
    #1;
    chk("same_rd1", Read_Data1_out, exp_same);
    chk("same_rd2", Read_Data2_out, exp_same);
    // The other port resolves on its own address.
    Read_Reg2_in = 5'd5;
    #1;
    chk("same_rd2_other", Read_Data2_out, 32'h1234_5678);
    Read_Reg2_in = 5'd3;
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("after_rd1", Read_Data1_out, 32'hA5A5_A5A5);
    chk("after_rd2", Read_Data2_out, 32'hA5A5_A5A5);

    // Reset collision on r7.
    drive_wr(1'b1, 1'b0, 32'd0, 32'h1111_1111, 5'd7);
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    Read_Reg1_in = 5'd7;
    Read_Reg2_in = 5'd5;
    #1;
    chk("pre_r7", Read_Data1_out, 32'h1111_1111);
    rst = 1'b1;
    drive_wr(1'b1, 1'b0, 32'd0, 32'h2222_2222, 5'd7);
    #1;
    chk("coll_rd1", Read_Data1_out, 32'd0);
    chk("coll_rd2", Read_Data2_out, 32'd0);
    chk("coll_valid", {31'd0, WB_Valid_out}, 32'd0);
    chk("coll_wbdata", WB_Data_out, 32'h2222_2222);
    step();
    rst = 1'b0;
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("coll_r7", Read_Data1_out, 32'd0);
    chk("coll_r5", Read_Data2_out, 32'd0);

    // Writes resume on the first edge after reset.
    drive_wr(1'b1, 1'b1, 32'h3333_3333, 32'd0, 5'd7);
    step();
    drive_wr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("resume_r7", Read_Data1_out, 32'h3333_3333);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
